// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a return-address stack.
//
// The PC advances by STEP on every update cycle (ready_q=1 and stall=0), or
// follows a redirect request: JUMP, CALL (pushes the return address), RET
// (pops it) or BRANCH_REL (signed offset from the current PC). ready_q is
// mem_ready delayed one cycle and gates every update.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   mem_ready         instruction memory delivered the current word
//   stall             downstream hold, blocks PC update
//   redirect_valid    control-flow request present
//   redirect_op       00 JUMP, 01 CALL, 10 RET, 11 BRANCH_REL
//   redirect_target   absolute target or two's-complement offset
//   pc_current        registered program counter
//   ready_q           mem_ready delayed one cycle
//   stack_count       number of valid return-stack entries
//   stack_overflow    one-cycle pulse: CALL with stack full
//   stack_underflow   one-cycle pulse: RET with stack empty
module pc_sequencer #(
  parameter int unsigned PC_WIDTH     = 10,
  parameter int unsigned RESET_VECTOR = 0,
  parameter int unsigned STEP         = 1,
  parameter int unsigned STACK_DEPTH  = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               mem_ready,
  input  logic                               stall,
  input  logic                               redirect_valid,
  input  logic [1:0]                         redirect_op,
  input  logic [PC_WIDTH-1:0]                redirect_target,
  output logic [PC_WIDTH-1:0]                pc_current,
  output logic                               ready_q,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   stack_count,
  output logic                               stack_overflow,
  output logic                               stack_underflow
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);
  localparam logic [PC_WIDTH-1:0] RV     = PC_WIDTH'(RESET_VECTOR);
  localparam logic [PC_WIDTH-1:0] STEP_W = PC_WIDTH'(STEP);

  typedef enum logic [1:0] {
    OP_JUMP   = 2'b00,
    OP_CALL   = 2'b01,
    OP_RET    = 2'b10,
    OP_BRANCH = 2'b11
  } redirect_op_e;

  logic [PC_WIDTH-1:0] stack_mem [STACK_DEPTH];
  logic [PC_WIDTH-1:0] stack_top;
  logic [PC_WIDTH-1:0] seq_pc;
  logic [PC_WIDTH-1:0] pc_next;
  redirect_op_e        op;
  logic                update;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                ovf_next;
  logic                unf_next;

  assign update = ready_q & ~stall;
  assign full   = (stack_count == CW'(STACK_DEPTH));
  assign empty  = (stack_count == '0);
  assign seq_pc = pc_current + STEP_W;

  always_comb begin
    op = redirect_op_e'(redirect_op);
  end

  // Top of stack lives at index stack_count-1; when empty the result is unused.
  always_comb begin
    stack_top = '0;
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (CW'(i) == stack_count - CW'(1)) stack_top = stack_mem[i];
    end
  end

  always_comb begin
    pc_next  = pc_current;
    push     = 1'b0;
    pop      = 1'b0;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    if (update) begin
      if (!redirect_valid) begin
        pc_next = seq_pc;
      end else begin
        case (op)
          OP_JUMP: pc_next = redirect_target;
          // Modular add of the offset gives signed-offset behaviour directly.
          OP_BRANCH: pc_next = pc_current + redirect_target;
          OP_CALL: begin
            pc_next = redirect_target;
            if (full) ovf_next = 1'b1;
            else      push     = 1'b1;
          end
          OP_RET: begin
            if (empty) begin
              pc_next  = seq_pc;
              unf_next = 1'b1;
            end else begin
              pc_next = stack_top;
              pop     = 1'b1;
            end
          end
          default: pc_next = seq_pc;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_current      <= RV;
      ready_q         <= 1'b0;
      stack_count     <= '0;
      stack_overflow  <= 1'b0;
      stack_underflow <= 1'b0;
    end else begin
      ready_q         <= mem_ready;
      pc_current      <= pc_next;
      stack_overflow  <= ovf_next;
      stack_underflow <= unf_next;
      if (push)     stack_count <= stack_count + CW'(1);
      else if (pop) stack_count <= stack_count - CW'(1);
    end
  end

  // Contents need no reset: stack_count alone defines which entries are valid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STACK_DEPTH; i++) begin
      if (!rst && push && stack_count == CW'(i)) stack_mem[i] <= seq_pc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed testbench for pc_sequencer with default parameters
// (PC_WIDTH=10, RESET_VECTOR=0, STEP=1, STACK_DEPTH=4).
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mem_ready = 1'b0;
  logic       stall = 1'b0;
  logic       redirect_valid = 1'b0;
  logic [1:0] redirect_op = 2'b00;
  logic [9:0] redirect_target = '0;
  logic [9:0] pc_current;
  logic       ready_q;
  logic [2:0] stack_count;
  logic       stack_overflow;
  logic       stack_underflow;

  int tests = 0;
  int fails = 0;

  localparam logic [1:0] JUMP = 2'b00, CALL = 2'b01, RET = 2'b10, BR = 2'b11;

  pc_sequencer #(
    .PC_WIDTH(10),
    .RESET_VECTOR(0),
    .STEP(1),
    .STACK_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_ready(mem_ready),
    .stall(stall),
    .redirect_valid(redirect_valid),
    .redirect_op(redirect_op),
    .redirect_target(redirect_target),
    .pc_current(pc_current),
    .ready_q(ready_q),
    .stack_count(stack_count),
    .stack_overflow(stack_overflow),
    .stack_underflow(stack_underflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Checks pc, count and both pulses together.
  task automatic check_all(input string tag, input logic [9:0] pc, input logic [2:0] cnt,
                           input logic ovf, input logic unf);
    check({tag, ".pc"}, 32'(pc_current), 32'(pc));
    check({tag, ".cnt"}, 32'(stack_count), 32'(cnt));
    check({tag, ".ovf"}, 32'(stack_overflow), 32'(ovf));
    check({tag, ".unf"}, 32'(stack_underflow), 32'(unf));
  endtask

  task automatic req(input logic v, input logic [1:0] op, input logic [9:0] tgt);
    redirect_valid  = v;
    redirect_op     = op;
    redirect_target = tgt;
  endtask

  initial begin
    // Reset with mem_ready high
    rst = 1'b1; mem_ready = 1'b1;
    tick();
    check_all("reset", 10'h000, 3'd0, 1'b0, 1'b0);
    check("reset.ready_q", 32'(ready_q), 32'd0);

    // Release: pc holds 0 for two cycles, then counts
    rst = 1'b0;
    tick();
    check("rel1.pc", 32'(pc_current), 32'h000);
    check("rel1.ready_q", 32'(ready_q), 32'd1);
    tick(); check("seq1", 32'(pc_current), 32'h001);
    tick(); check("seq2", 32'(pc_current), 32'h002);
    tick(); check("seq3", 32'(pc_current), 32'h003);

    // Wraparound 0x3FF -> 0x000
    req(1'b1, JUMP, 10'h3FE); tick(); check("wrap.jump", 32'(pc_current), 32'h3FE);
    req(1'b0, JUMP, 10'h000); tick(); check("wrap.3ff", 32'(pc_current), 32'h3FF);
    tick(); check("wrap.000", 32'(pc_current), 32'h000);

    // mem_ready toggling: advance only on cycles following mem_ready=1
    mem_ready = 1'b0; tick();
    check("tog1.pc", 32'(pc_current), 32'h001); check("tog1.rq", 32'(ready_q), 32'd0);
    mem_ready = 1'b1; tick();
    check("tog2.pc", 32'(pc_current), 32'h001); check("tog2.rq", 32'(ready_q), 32'd1);
    mem_ready = 1'b0; tick();
    check("tog3.pc", 32'(pc_current), 32'h002);
    mem_ready = 1'b1; tick();
    check("tog4.pc", 32'(pc_current), 32'h002);
    tick(); check("tog5.pc", 32'(pc_current), 32'h003);

    // Stall holds pc and ignores redirects; ready_q keeps tracking mem_ready
    stall = 1'b1; tick();
    check("stall1.pc", 32'(pc_current), 32'h003); check("stall1.rq", 32'(ready_q), 32'd1);
    req(1'b1, JUMP, 10'h155); tick();
    check("stall2.pc", 32'(pc_current), 32'h003);
    stall = 1'b0; req(1'b0, JUMP, 10'h000); tick();
    check("unstall.pc", 32'(pc_current), 32'h004);

    // Simple CALL / RET
    req(1'b1, JUMP, 10'h010); tick(); check("j010", 32'(pc_current), 32'h010);
    req(1'b1, CALL, 10'h100); tick(); check_all("call1", 10'h100, 3'd1, 1'b0, 1'b0);
    req(1'b1, RET,  10'h3C3); tick(); check_all("ret1",  10'h011, 3'd0, 1'b0, 1'b0);

    // Nested calls to overflow, then unwind to underflow
    req(1'b1, CALL, 10'h020); tick(); check_all("nc1", 10'h020, 3'd1, 1'b0, 1'b0);
    req(1'b1, CALL, 10'h040); tick(); check_all("nc2", 10'h040, 3'd2, 1'b0, 1'b0);
    req(1'b1, CALL, 10'h080); tick(); check_all("nc3", 10'h080, 3'd3, 1'b0, 1'b0);
    req(1'b1, CALL, 10'h200); tick(); check_all("nc4", 10'h200, 3'd4, 1'b0, 1'b0);
    req(1'b1, CALL, 10'h300); tick(); check_all("nc5.ovf", 10'h300, 3'd4, 1'b1, 1'b0);
    req(1'b1, RET,  10'h000); tick(); check_all("nr1", 10'h081, 3'd3, 1'b0, 1'b0);
    tick(); check_all("nr2", 10'h041, 3'd2, 1'b0, 1'b0);
    tick(); check_all("nr3", 10'h021, 3'd1, 1'b0, 1'b0);
    tick(); check_all("nr4", 10'h012, 3'd0, 1'b0, 1'b0);
    tick(); check_all("nr5.unf", 10'h013, 3'd0, 1'b0, 1'b1);
    req(1'b0, JUMP, 10'h000); tick(); check_all("post_unf", 10'h014, 3'd0, 1'b0, 1'b0);

    // Relative branches and jump
    req(1'b1, JUMP, 10'h005); tick(); check("j005", 32'(pc_current), 32'h005);
    req(1'b1, BR,   10'h3FE); tick(); check("br_neg2", 32'(pc_current), 32'h003);
    req(1'b1, BR,   10'h010); tick(); check("br_pos16", 32'(pc_current), 32'h013);
    req(1'b1, JUMP, 10'h2AA); tick(); check("j2aa", 32'(pc_current), 32'h2AA);

    // Reset in the middle of a call sequence
    req(1'b1, CALL, 10'h100); tick();
    req(1'b1, CALL, 10'h101); tick();
    req(1'b1, CALL, 10'h102); tick(); check_all("pre_rst", 10'h102, 3'd3, 1'b0, 1'b0);
    rst = 1'b1; req(1'b1, CALL, 10'h1FF); tick();
    check_all("mid_rst", 10'h000, 3'd0, 1'b0, 1'b0);
    check("mid_rst.rq", 32'(ready_q), 32'd0);
    rst = 1'b0; req(1'b0, JUMP, 10'h000); tick();
    check("rst_rel1", 32'(pc_current), 32'h000);
    tick(); check("rst_rel2", 32'(pc_current), 32'h001);
    req(1'b1, RET, 10'h000); tick();
    check_all("rst_empty_ret", 10'h002, 3'd0, 1'b0, 1'b1);
    req(1'b0, JUMP, 10'h000); tick();
    check("pulse_clear", 32'(stack_underflow), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
